// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and sizing helper for the multi-cycle mul/div unit
package muldiv_pkg;
  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MLA  = 2'b01,
    OP_UDIV = 2'b10,
    OP_SDIV = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one shift-add multiply or restoring-divide iteration per step
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] quot
);
  logic [WIDTH-1:0] x, y, z, x_n, y_n, z_n;
  logic [WIDTH:0] sh, diff;
  logic ge;
  // next iteration: x is multiplicand/divisor, y is multiplier/dividend-becoming-quotient, z is product/remainder
  always_comb begin
    sh   = {z, y[WIDTH-1]};
    diff = sh - {1'b0, x};
    ge   = ~diff[WIDTH];
    x_n  = div ? x : x << 1;
    y_n  = div ? {y[WIDTH-2:0], ge} : y >> 1;
    z_n  = div ? (ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0]) : z + (y[0] ? x : '0);
  end
  // operand registers: load fresh operands, then advance one iteration per step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
      z <= '0;
    end else if (load) begin
      x <= x_in;
      y <= y_in;
      z <= '0;
    end else if (step) begin
      x <= x_n;
      y <= y_n;
      z <= z_n;
    end
  end
  assign prod = z;
  assign quot = y;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for MUL/MLA/UDIV/SDIV with busy/done handshake and sign fix-up
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);
  localparam int CW = clog2(WIDTH) > 0 ? clog2(WIDTH) : 1;
  state_e state, state_n;
  op_e op_r;
  logic [WIDTH-1:0] a_r, b_r, acc_r, a_mag, b_mag, prod, quot;
  logic [CW-1:0] cnt;
  logic neg_r, is_div, is_sdiv, b_zero;
  assign is_div  = op_r[1];
  assign is_sdiv = op_r == OP_SDIV;
  assign a_mag   = is_sdiv && a_r[WIDTH-1] ? -a_r : a_r;
  assign b_mag   = is_sdiv && b_r[WIDTH-1] ? -b_r : b_r;
  assign b_zero  = b_r == '0;
  assign busy    = state != S_IDLE;
  assign done    = state == S_DONE;
  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (state == S_PREP),
    .step  (state == S_RUN),
    .div   (is_div),
    .x_in  (is_div ? b_mag : a_r),
    .y_in  (is_div ? a_mag : b_r),
    .prod  (prod),
    .quot  (quot)
  );
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_n;
  end
  // next state: divide by zero skips straight to DONE, RUN lasts WIDTH cycles
  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE:  state_n = start ? S_PREP : S_IDLE;
      S_PREP:  state_n = is_div && b_zero ? S_DONE : S_RUN;
      S_RUN:   state_n = cnt == '0 ? S_FIX : S_RUN;
      S_FIX:   state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  // operand capture, iteration counter, quotient sign and result fix-up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r        <= OP_MUL;
      a_r         <= '0;
      b_r         <= '0;
      acc_r       <= '0;
      neg_r       <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_r        <= op_e'(op);
          a_r         <= a;
          b_r         <= b;
          acc_r       <= acc;
          div_by_zero <= 1'b0;
        end
        S_PREP: begin
          neg_r <= is_sdiv && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          cnt   <= CW'(WIDTH - 1);
          if (is_div && b_zero) begin
            result      <= '0;
            div_by_zero <= 1'b1;
          end
        end
        S_RUN: cnt <= cnt - CW'(1);
        S_FIX: result <= op_r == OP_MLA ? prod + acc_r : !is_div ? prod : neg_r ? -quot : quot;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors with an arithmetic reference model checked every cycle
module tb_muldiv_seq;
  logic clk, reset, start, busy, done, div_by_zero;
  logic [1:0] op;
  logic [31:0] a, b, acc, result;
  int checks = 0, errors = 0;
  logic act = 0, exp_dbz = 0, hdbz = 0;
  int k = 0, lat = 0;
  logic [31:0] exp_res = 0, held = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .acc(acc),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, y, z);
    if (o == 2'b00) return x * y;
    if (o == 2'b01) return x * y + z;
    if (y == 0) return 0;
    if (o == 2'b10) return x / y;
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
    return $signed(x) / $signed(y);
  endfunction

  // reference timeline: accepted start opens an operation lasting lat cycles
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      act = 0; k = 0; held = 0; hdbz = 0;
    end else if (act) begin
      if (k == lat) begin
        act = 0; held = exp_res; hdbz = exp_dbz;
      end else k++;
    end else if (start) begin
      act = 1; k = 1;
      exp_dbz = op[1] && b == 0;
      lat = exp_dbz ? 2 : 35;
      exp_res = model(op, a, b, acc);
      hdbz = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("busy", {31'b0, busy}, {31'b0, act});
      chk("done", {31'b0, done}, {31'b0, act && k == lat});
      if (act && k == lat) begin
        chk("m_result", result, exp_res);
        chk("m_dbz", {31'b0, div_by_zero}, {31'b0, exp_dbz});
      end else if (!act) begin
        chk("hold_result", result, held);
        chk("hold_dbz", {31'b0, div_by_zero}, {31'b0, hdbz});
      end
    end
  end

  task automatic run(input string nm, input logic [1:0] o, input logic [31:0] x, y, z,
                     input logic [31:0] er, input logic ed, input int el);
    int n;
    n = 0;
    @(negedge clk);
    op = o; a = x; b = y; acc = z; start = 1;
    @(posedge clk);
    do begin
      @(negedge clk);
      start = 0; a = ~a; b = b + 1; acc = ~acc;
      n++;
    end while (!done && n < 60);
    chk({nm, "_lat"}, n, el);
    chk({nm, "_res"}, result, er);
    chk({nm, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ed});
  endtask

  initial begin
    int pulses;
    reset = 0; start = 0; op = 0; a = 0; b = 0; acc = 0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_result", result, 0);
    chk("rst_dbz", {31'b0, div_by_zero}, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    run("mul7x6", 2'b00, 7, 6, 0, 42, 0, 35);
    run("mla_wrap", 2'b01, 32'hFFFF_FFFF, 2, 5, 3, 0, 35);
    run("mul_ovf", 2'b00, 32'h1_0000, 32'h1_0000, 0, 0, 0, 35);
    run("udiv", 2'b10, 100, 7, 0, 14, 0, 35);
    run("sdiv_neg", 2'b11, -32'd100, 7, 0, 32'hFFFF_FFF2, 0, 35);
    run("sdiv_negb", 2'b11, 100, -32'd7, 0, 32'hFFFF_FFF2, 0, 35);
    run("sdiv_both", 2'b11, -32'd100, -32'd7, 0, 14, 0, 35);
    run("sdiv_min", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0, 35);
    run("udiv_big", 2'b10, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0, 35);
    run("udiv_zero", 2'b10, 5, 0, 0, 0, 1, 2);
    run("mul3x3", 2'b00, 3, 3, 0, 9, 0, 35);
    run("sdiv_zero", 2'b11, -32'd9, 0, 0, 0, 1, 2);
    run("mla", 2'b01, 1000, 1000, 7, 1000007, 0, 35);
    // restart attempts while running are ignored
    @(negedge clk);
    op = 2'b00; a = 11; b = 13; start = 1;
    @(posedge clk);
    pulses = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      start = i >= 10 && i <= 12;
      op = 2'b10; a = 99; b = 3;
      if (done) begin
        pulses++;
        chk("restart_res", result, 143);
      end
    end
    chk("restart_pulses", pulses, 1);
    // asynchronous reset in the middle of RUN
    @(negedge clk);
    op = 2'b00; a = 5; b = 5; start = 1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    start = 0;
    #2 reset = 0;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_done", {31'b0, done}, 0);
    chk("arst_result", result, 0);
    chk("arst_dbz", {31'b0, div_by_zero}, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    run("mul2x3", 2'b00, 2, 3, 0, 6, 0, 35);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
